// File: rtl/gaus_pkg.sv
// gaus_pkg: shared FSM states, default kernel constants and result rounding for the Gaussian passes
package gaus_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;
  localparam logic [55:0] COEF_DEF = 56'h01_06_0F_14_0F_06_01;
  localparam int SHIFT_DEF = 6;
  localparam int LAT_DEF = 6;
  function automatic logic [7:0] sat8(input logic [15:0] v, input int shift);
    logic [16:0] s;
    s = ({1'b0, v} + (17'd1 << (shift - 1))) >> shift;
    return s > 17'd255 ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/gaus_line_feeder_if.sv
// gaus_line_feeder_if: pixel input, gaus_line issue/result and filtered output bundle
interface gaus_line_feeder_if;
  logic [7:0] pix_in;
  logic pix_valid, pix_ready;
  logic [55:0] g_a, g_b;
  logic g_start;
  logic [15:0] g_result;
  logic g_finish;
  logic [7:0] out_pix;
  logic out_valid, out_ready, out_last;
  modport master (
    input pix_in, pix_valid, g_result, g_finish, out_ready,
    output pix_ready, g_a, g_b, g_start, out_pix, out_valid, out_last
  );
  modport slave (
    output pix_in, pix_valid, g_result, g_finish, out_ready,
    input pix_ready, g_a, g_b, g_start, out_pix, out_valid, out_last
  );
endinterface

// File: rtl/gaus_res_fifo.sv
// gaus_res_fifo: synchronous FIFO holding scaled gaus_line results until downstream takes them
module gaus_res_fifo #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic [7:0] din,
  input logic pop,
  output logic [7:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH + 1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? 8'd0 : mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + AW'(1);
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/gaus_line_feeder.sv
// gaus_line_feeder: builds edge-replicated 7-pixel windows for gaus_line and scales its results
module gaus_line_feeder
  import gaus_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter logic [55:0] COEF = COEF_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int LAT = LAT_DEF,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  gaus_line_feeder_if.master bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int QW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nxt;
  logic [7:0] w [7];
  logic [7:0] w_nxt [7];
  logic [55:0] ga_nxt;
  logic [CW-1:0] col, ocol;
  logic [1:0] fcnt;
  logic [OW-1:0] outstanding, count;
  logic [QW-1:0] quar;
  logic credit, accept, issue, pop, push, full, empty;
  logic [7:0] res;
  always_comb begin
    credit = outstanding < OW'(DEPTH);
    bus.pix_ready = state != FLUSH && quar == '0 && credit;
    accept = bus.pix_valid && bus.pix_ready;
    state_nxt = state;
    issue = 1'b0;
    case (state)
      IDLE: state_nxt = accept ? PRIME : IDLE;
      PRIME: if (accept && col == CW'(3)) begin
        issue = 1'b1;
        state_nxt = col == LAST ? FLUSH : RUN;
      end
      RUN: if (accept) begin
        issue = 1'b1;
        state_nxt = col == LAST ? FLUSH : RUN;
      end
      FLUSH: if (credit) begin
        issue = 1'b1;
        state_nxt = fcnt == 2'd2 ? IDLE : FLUSH;
      end
      default: ;
    endcase
    // column 0 fills every tap (left edge); FLUSH repeats the last pixel (right edge)
    for (int k = 0; k < 6; k++) w_nxt[k] = state == IDLE ? bus.pix_in : w[k + 1];
    w_nxt[6] = state == FLUSH ? w[6] : bus.pix_in;
    ga_nxt = '0;
    for (int k = 0; k < 7; k++) ga_nxt[8*k +: 8] = w_nxt[k];
  end
  assign pop = bus.out_valid && bus.out_ready;
  assign push = bus.g_finish && quar == '0;
  assign res = sat8(bus.g_result, SHIFT);
  assign bus.out_valid = !empty;
  assign bus.out_last = ocol == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      for (int k = 0; k < 7; k++) w[k] <= '0;
      col <= '0;
      ocol <= '0;
      fcnt <= '0;
      outstanding <= '0;
      quar <= QW'(LAT);
      bus.g_a <= '0;
      bus.g_b <= '0;
      bus.g_start <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept || issue) w <= w_nxt;
      if (accept) col <= state == IDLE ? CW'(1) : col + CW'(1);
      fcnt <= state != FLUSH ? 2'd0 : issue ? fcnt + 2'd1 : fcnt;
      // gaus_line has no reset, so results in flight across a reset are dropped here
      quar <= quar == '0 ? '0 : quar - QW'(1);
      outstanding <= issue && !pop ? outstanding + OW'(1) : !issue && pop ? outstanding - OW'(1) : outstanding;
      if (pop) ocol <= ocol == LAST ? '0 : ocol + CW'(1);
      if (issue) bus.g_a <= ga_nxt;
      bus.g_b <= COEF;
      bus.g_start <= issue;
    end
  gaus_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(res),
    .pop(pop),
    .dout(bus.out_pix),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assert property (@(posedge clk) disable iff (!rst_n) count <= outstanding);
  assert property (@(posedge clk) disable iff (!rst_n) full |-> outstanding == OW'(DEPTH));
endmodule
